// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode/operand-read slice.
// Defines XLEN, NREG, AW, REG_ZERO and reg_idx_t.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one write.
// Ports: clk, rst (sync, active-high), we/waddr/wdata write port,
// raddr1/raddr2 -> rdata1/rdata2. x0 reads zero and ignores writes.
// Optional macro RF_BYPASS_EN: same-cycle write is forwarded to reads.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] mem [NREG];
  logic            wr;

  assign wr = we && (waddr != ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wr) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != ZERO)
      rdata1 = (wr && waddr == raddr1) ? wdata : mem[raddr1];
    if (raddr2 != ZERO)
      rdata2 = (wr && waddr == raddr2) ? wdata : mem[raddr2];
  end
`else
  // Reads see the pre-write value; decode must stall to observe it.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != ZERO)
      rdata1 = mem[raddr1];
    if (raddr2 != ZERO)
      rdata2 = mem[raddr2];
  end
`endif

endmodule

// File: rtl/decode_operand_stage.sv
// Decode operand read plus ID/EX pipeline register with stall/flush.
// Ports: clk, rst, decode fields (*_D, PCD, ...), writeback port
// (RegWriteW/RDW/ResultW), EnE/FlushE control, execute fields (*_E).
// Macro RF_BYPASS_EN enables write-through bypass in the register file.
module decode_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   RS1_D,
  input  logic [AW-1:0]   RS2_D,
  input  logic [AW-1:0]   RD_D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic            ValidD,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            EnE,
  input  logic            FlushE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [AW-1:0]   RS1_E,
  output logic [AW-1:0]   RS2_E,
  output logic [AW-1:0]   RD_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ImmExtE,
  output logic            ValidE
);

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RDW),
    .wdata  (ResultW),
    .raddr1 (RS1_D),
    .raddr2 (RS2_D),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // rst > FlushE > EnE > hold; a flush wins even while stalled.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RD1_E    <= '0;
      RD2_E    <= '0;
      RS1_E    <= '0;
      RS2_E    <= '0;
      RD_E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      ValidE   <= 1'b0;
    end else if (EnE) begin
      RD1_E    <= rd1;
      RD2_E    <= rd2;
      RS1_E    <= RS1_D;
      RS2_E    <= RS2_D;
      RD_E     <= RD_D;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      ImmExtE  <= ImmExtD;
      ValidE   <= ValidD;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Randomized + directed bench for decode_operand_stage.
// Reference model: register array and expected ID/EX contents.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_D, RS2_D, RD_D, RDW;
  logic [31:0] PCD, PCPlus4D, ImmExtD, ResultW;
  logic        ValidD, RegWriteW, EnE, FlushE;
  logic [31:0] RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic        ValidE;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m [32];
  logic [31:0] e_rd1, e_rd2, e_pc, e_pc4, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        e_v;

  decode_operand_stage dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .ValidD(ValidD), .RegWriteW(RegWriteW), .RDW(RDW),
    .ResultW(ResultW), .EnE(EnE), .FlushE(FlushE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .RS1_E(RS1_E),
    .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .ValidE(ValidE)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (RegWriteW && RDW == a) return ResultW;
`endif
    return m[a];
  endfunction

  // Advance one clock, updating the reference model from current inputs.
  task automatic tick();
    if (rst || FlushE) begin
      {e_rd1, e_rd2, e_pc, e_pc4, e_imm} = '0;
      {e_rs1, e_rs2, e_rd, e_v} = '0;
    end else if (EnE) begin
      e_rd1 = rd_model(RS1_D);
      e_rd2 = rd_model(RS2_D);
      e_rs1 = RS1_D; e_rs2 = RS2_D; e_rd = RD_D;
      e_pc = PCD; e_pc4 = PCPlus4D; e_imm = ImmExtD;
      e_v = ValidD;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
    end else if (RegWriteW && RDW != 0) begin
      m[RDW] = ResultW;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; RS1_D = 0; RS2_D = 0; RD_D = 0;
    PCD = 0; PCPlus4D = 0; ImmExtD = 0; ValidD = 0;
    RegWriteW = 0; RDW = 0; ResultW = 0;
    EnE = 1; FlushE = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    PCD = 32'h55; ValidD = 1; RS1_D = 5;
    tick();
    n_cmp++;
    if ({RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE, RS1_E, RS2_E,
         RD_E, ValidE} !== '0) begin
      n_err++;
      $display("FAIL reset_state got pce=%h v=%b rd1=%h want all 0",
               PCE, ValidE, RD1_E);
    end
    idle();
    RS1_D = 5; ValidD = 1;
    tick();
    n_cmp++;
    if (RD1_E !== 32'h0 || ValidE !== 1'b1) begin
      n_err++;
      $display("FAIL reset_read_x5 got rd1=%h v=%b want 0/1",
               RD1_E, ValidE);
    end
  endtask

  task automatic test_x0();
    idle();
    RegWriteW = 1; RDW = 0; ResultW = 32'hDEADBEEF;
    RS1_D = 0; RS2_D = 0;
    tick();
    n_cmp++;
    if (RD1_E !== 32'h0 || RD2_E !== 32'h0) begin
      n_err++;
      $display("FAIL x0_same_cycle got %h/%h want 0", RD1_E, RD2_E);
    end
    idle();
    RS1_D = 0;
    tick();
    n_cmp++;
    if (RD1_E !== 32'h0) begin
      n_err++;
      $display("FAIL x0_write_dropped got %h want 0", RD1_E);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] want;
    idle();
    RegWriteW = 1; RDW = 7; ResultW = 32'h12345678;
    RS2_D = 7; RS1_D = 7;
`ifdef RF_BYPASS_EN
    want = 32'h12345678;
`else
    want = 32'h0;
`endif
    tick();
    n_cmp++;
    if (RD2_E !== want || RD1_E !== want) begin
      n_err++;
      $display("FAIL hazard_same_cycle got %h/%h want %h",
               RD1_E, RD2_E, want);
    end
    idle();
    RS2_D = 7;
    tick();
    n_cmp++;
    if (RD2_E !== 32'h12345678) begin
      n_err++;
      $display("FAIL hazard_next_cycle got %h want 12345678", RD2_E);
    end
  endtask

  task automatic test_stall();
    idle();
    PCD = 32'h100; PCPlus4D = 32'h104; ImmExtD = 32'hFFFF_FFF0;
    RS2_D = 7; RD_D = 9; ValidD = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      EnE = 0;
      PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
      RS1_D = 5'($urandom); RS2_D = 5'($urandom);
      RD_D = 5'($urandom); ValidD = 0;
      RegWriteW = 1; RDW = 7; ResultW = $urandom | 32'h1;
      tick();
      n_cmp++;
      if (PCE !== 32'h100 || PCPlus4E !== 32'h104 ||
          ImmExtE !== 32'hFFFF_FFF0 || RD_E !== 5'd9 ||
          RD2_E !== 32'h12345678 || ValidE !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got pce=%h rd2=%h v=%b want 100/12345678/1",
                 i, PCE, RD2_E, ValidE);
      end
    end
  endtask

  task automatic test_flush();
    idle();
    EnE = 0; FlushE = 1; PCD = 32'h200; ValidD = 1; RS1_D = 7;
    tick();
    n_cmp++;
    if ({RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE, RS1_E, RS2_E,
         RD_E, ValidE} !== '0) begin
      n_err++;
      $display("FAIL flush_bubble got pce=%h v=%b rd1=%h want 0",
               PCE, ValidE, RD1_E);
    end
  endtask

  task automatic test_reset_clears_rf();
    idle();
    RegWriteW = 1; RDW = 3; ResultW = 32'hA5A5A5A5;
    tick();
    idle();
    RS1_D = 3;
    tick();
    n_cmp++;
    if (RD1_E !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL x3_written got %h want a5a5a5a5", RD1_E);
    end
    idle();
    rst = 1;
    tick();
    idle();
    RS1_D = 3;
    tick();
    n_cmp++;
    if (RD1_E !== 32'h0) begin
      n_err++;
      $display("FAIL x3_after_reset got %h want 0", RD1_E);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      EnE = ($urandom_range(0, 9) < 7);
      RS1_D = 5'($urandom); RS2_D = 5'($urandom);
      RD_D = 5'($urandom);
      if ($urandom_range(0, 3) == 0) RS2_D = RS1_D;
      PCD = $urandom; PCPlus4D = PCD + 4; ImmExtD = $urandom;
      ValidD = 1'($urandom);
      RegWriteW = ($urandom_range(0, 3) != 0);
      RDW = ($urandom_range(0, 2) == 0) ? RS1_D : 5'($urandom);
      ResultW = $urandom;
      tick();
      n_cmp++;
      if ({RD1_E, RD2_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E,
           ImmExtE, ValidE} !==
          {e_rd1, e_rd2, e_rs1, e_rs2, e_rd, e_pc, e_pc4,
           e_imm, e_v}) begin
        n_err++;
        $display("FAIL random[%0d] got rd1=%h rd2=%h pce=%h v=%b want rd1=%h rd2=%h pce=%h v=%b",
                 c, RD1_E, RD2_E, PCE, ValidE, e_rd1, e_rd2, e_pc, e_v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    idle();
    @(negedge clk);
    test_reset();
    test_x0();
    test_hazard();
    test_stall();
    test_flush();
    test_reset_clears_rf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
